// File: rtl/staged_reset_sequencer_pkg.sv
// Shared types and width helpers for the staged reset sequencer.
// Contents:
//   state_e     - sequencer phase (HOLD, RELEASE, RUN)
//   cnt_width   - counter width able to hold max(RESET_CYCLE, STAGE_GAP)
//   idx_width   - stage-index width able to hold NUM_STAGES
package staged_reset_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_e;

  function automatic int cnt_width(input int reset_cycle, input int stage_gap);
    int max_v;
    max_v = (reset_cycle > stage_gap) ? reset_cycle : stage_gap;
    return $clog2(max_v + 1);
  endfunction

  function automatic int idx_width(input int num_stages);
    return $clog2(num_stages + 1);
  endfunction

endpackage

// File: rtl/staged_reset_sequencer_if.sv
// Request/status bundle between the reset sequencer and its consumers.
// Signals:
//   swRstReq - synchronous active-high software reset request
//   rstOut   - active-high per-stage resets, bit 0 released first
//   ready    - high once every stage is released
// master: the requester/consumer side; slave: the sequencer itself.
interface staged_reset_sequencer_if #(
  parameter int NUM_STAGES = 4
);
  logic                  swRstReq;
  logic [NUM_STAGES-1:0] rstOut;
  logic                  ready;

  modport master (output swRstReq, input rstOut, input ready);
  modport slave  (input swRstReq, output rstOut, output ready);
endinterface

// File: rtl/staged_reset_sequencer_chk.sv
// Property checker for the staged reset sequencer outputs.
// Ports:
//   clk, rstN - same clock/reset as the sequencer
//   rstOut    - per-stage resets observed
//   ready     - ready flag observed
// Release must be monotonic (a stage is low only if every lower stage is
// low) and ready may only be high with every stage released.
module staged_reset_sequencer_chk #(
  parameter int NUM_STAGES = 4
) (
  input logic                  clk,
  input logic                  rstN,
  input logic [NUM_STAGES-1:0] rstOut,
  input logic                  ready
);

  logic [NUM_STAGES-1:0] rel_s;
  logic                  mono_s;

  // Released stages must form a contiguous run starting at bit 0.
  assign rel_s  = ~rstOut;
  assign mono_s = ((rel_s & (rel_s + NUM_STAGES'(1))) == '0);

  a_monotonic: assert property (@(posedge clk) disable iff (!rstN) mono_s)
    else $error("release order violated: rstOut=%b", rstOut);

  a_ready: assert property (@(posedge clk) disable iff (!rstN) (!ready || (rstOut == '0)))
    else $error("ready high with stages in reset: rstOut=%b", rstOut);

endmodule

// File: rtl/staged_reset_sequencer_reset_synchronizer.sv
// Reset synchronizer: asserts immediately when rstN falls, releases
// rstSync SYNC_STAGES rising edges after rstN rises.
// Ports:
//   clk     - destination clock
//   rstN    - asynchronous active-low reset input
//   rstSync - synchronized active-low reset (1 = released)
module reset_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstN,
  output logic rstSync
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift chain: cleared asynchronously, fills with ones after release.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rstSync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/staged_reset_sequencer.sv
// Staged reset sequencer: holds all downstream resets for RESET_CYCLE
// cycles after the last trigger, then releases them one by one, bit 0
// first, STAGE_GAP cycles apart. Board reset asserts everything
// asynchronously; release is always synchronous to clk.
// Ports:
//   clk  - clock
//   rstN - asynchronous active-low board reset
//   bus  - slave side: swRstReq in, rstOut/ready out (all registered)
module staged_reset_sequencer
  import staged_reset_pkg::*;
#(
  parameter int NUM_STAGES  = 4,
  parameter int RESET_CYCLE = 16,
  parameter int STAGE_GAP   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                            clk,
  input  logic                            rstN,
  staged_reset_sequencer_if.slave         bus
);

  localparam int CW = cnt_width(RESET_CYCLE, STAGE_GAP);
  localparam int IW = idx_width(NUM_STAGES);

  localparam logic [CW-1:0] HOLD_LOAD = CW'(RESET_CYCLE - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(STAGE_GAP - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_STAGES - 1);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_STAGES-1:0] rst_out_q, rst_out_d;
  logic                  ready_q, ready_d;
  logic                  rst_sync_s;
  logic                  trig_s;

  reset_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rstN    (rstN),
    .rstSync (rst_sync_s)
  );

  // A trigger is either a still-synchronizing board reset or a software request.
  assign trig_s = ~rst_sync_s | bus.swRstReq;

  // State, counters and outputs; board reset forces the full-hold state.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= HOLD;
      cnt_q     <= HOLD_LOAD;
      idx_q     <= '0;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
    end
  end

  // Next-state logic; a trigger overrides every other transition.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;
    ready_d   = ready_q;
    if (trig_s) begin
      state_d   = HOLD;
      cnt_d     = HOLD_LOAD;
      idx_d     = '0;
      rst_out_d = '1;
      ready_d   = 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          rst_out_d = '1;
          ready_d   = 1'b0;
          if (cnt_q == '0) begin
            rst_out_d[0] = 1'b0;
            cnt_d        = GAP_LOAD;
            idx_d        = IW'(1);
            if (NUM_STAGES == 1) begin
              state_d = RUN;
              ready_d = 1'b1;
            end else begin
              state_d = RELEASE;
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        RELEASE: begin
          ready_d = 1'b0;
          if (cnt_q == '0) begin
            // Clear only the stage selected by idx_q; lower stages are already low.
            for (int i = 0; i < NUM_STAGES; i++) begin
              if (idx_q == IW'(i)) begin
                rst_out_d[i] = 1'b0;
              end else begin
                rst_out_d[i] = rst_out_q[i];
              end
            end
            idx_d = idx_q + IW'(1);
            cnt_d = GAP_LOAD;
            if (idx_q == LAST_IDX) begin
              state_d = RUN;
              ready_d = 1'b1;
            end else begin
              state_d = RELEASE;
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        RUN: begin
          rst_out_d = '0;
          ready_d   = 1'b1;
        end
        default: begin
          state_d   = HOLD;
          cnt_d     = HOLD_LOAD;
          idx_d     = '0;
          rst_out_d = '1;
          ready_d   = 1'b0;
        end
      endcase
    end
  end

  assign bus.rstOut = rst_out_q;
  assign bus.ready  = ready_q;

endmodule
